// File: rtl/spiker_pkg.sv
// rtl/spiker_pkg.sv - shared constants, state type and LFSR step for the spike encoder
//
// Purpose: LFSR width/taps/seed, the encoder occupancy state enum and the
// single-step Galois LFSR function used by spike_lfsr.
package spiker_pkg;

  localparam int          LFSR_W    = 16;
  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // IDLE: no frame; ENCODE: active frame only; FULL: active and shadow frames
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_FULL   = 2'd2
  } enc_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/spike_lfsr.sv
// rtl/spike_lfsr.sv - 16-bit Galois LFSR random source for the spike encoder
//
// Purpose: free-standing pseudo-random generator that advances one step per
// enabled cycle. A non-zero seed keeps it off the all-zero lock-up state.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, loads LFSR_SEED
//   en     - advance one step this cycle
//   value  - current LFSR state
module spike_lfsr
  import spiker_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] value_q;
  logic [LFSR_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (en) begin
      value_d = lfsr_next(value_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= LFSR_SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// rtl/spike_rate_encoder.sv - rate-codes pixel frames into per-timestep spike vectors
//
// Purpose: double-buffered (active + shadow) frame store; each accepted
// sample compares every lane's intensity with a slice of the LFSR and
// registers the resulting spike vector for the network.
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   pix_valid    - pix_data holds a frame
//   pix_ready    - a frame can be accepted this cycle (shadow empty)
//   pix_data     - N_INPUTS lanes of PIX_W bits, lane i at [i*PIX_W +: PIX_W]
//   sample       - network request for the next timestep
//   sample_ready - a frame is loaded with steps remaining
//   in_spikes    - registered spike vector
//   frame_done   - one-cycle pulse after the last step of a frame
module spike_rate_encoder
  import spiker_pkg::*;
#(
  parameter int N_INPUTS   = 4,
  parameter int PIX_W      = 8,
  parameter int N_STEPS    = 10,
  parameter int STEP_CNT_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [N_INPUTS*PIX_W-1:0] pix_data,
  input  logic                      sample,
  output logic                      sample_ready,
  output logic [N_INPUTS-1:0]       in_spikes,
  output logic                      frame_done
);

  if (2 * (N_INPUTS - 1) + PIX_W > LFSR_W) begin : g_bad_lane_width
    $error("spike_rate_encoder: lane random slices exceed the LFSR width");
  end
  if (N_STEPS < 1 || N_STEPS > (1 << STEP_CNT_W) - 1) begin : g_bad_step_cnt
    $error("spike_rate_encoder: N_STEPS does not fit STEP_CNT_W");
  end

  localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(N_STEPS - 1);

  enc_state_e                state_q;
  logic [N_INPUTS*PIX_W-1:0] active_pix_q;
  logic [N_INPUTS*PIX_W-1:0] shadow_pix_q;
  logic [STEP_CNT_W-1:0]     step_cnt_q;
  logic [N_INPUTS-1:0]       in_spikes_q;
  logic                      frame_done_q;

  logic                      active_valid;
  logic                      shadow_valid;
  logic                      handshake;
  logic                      step_fire;
  logic                      last_fire;
  logic [N_INPUTS-1:0]       spikes_d;
  logic [LFSR_W-1:0]         lfsr_value;

  // Valid flags are decoded from the occupancy state so they can never disagree
  assign active_valid = (state_q != ST_IDLE);
  assign shadow_valid = (state_q == ST_FULL);

  assign pix_ready    = !shadow_valid;
  assign sample_ready = active_valid;
  assign handshake    = pix_valid && !shadow_valid;
  assign step_fire    = sample && active_valid;
  assign last_fire    = step_fire && (step_cnt_q == LAST_STEP);

  spike_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (step_fire),
    .value (lfsr_value)
  );

  // Spike when the intensity beats this lane's random slice, so the
  // firing probability is proportional to intensity.
  always_comb begin
    spikes_d = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      spikes_d[i] = active_pix_q[i*PIX_W +: PIX_W] > lfsr_value[2*i +: PIX_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      active_pix_q <= '0;
      shadow_pix_q <= '0;
      step_cnt_q   <= '0;
      in_spikes_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_fire;

      if (step_fire) begin
        in_spikes_q <= spikes_d;
      end else if (!active_valid) begin
        in_spikes_q <= '0;
      end

      if (step_fire) begin
        step_cnt_q <= last_fire ? '0 : step_cnt_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            active_pix_q <= pix_data;
            state_q      <= ST_ENCODE;
          end
        end
        ST_ENCODE: begin
          if (last_fire) begin
            // A frame arriving on the final step goes straight to active
            if (handshake) begin
              active_pix_q <= pix_data;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (handshake) begin
            shadow_pix_q <= pix_data;
            state_q      <= ST_FULL;
          end
        end
        ST_FULL: begin
          // pix_ready is low here, so no handshake can coincide
          if (last_fire) begin
            active_pix_q <= shadow_pix_q;
            state_q      <= ST_ENCODE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_spikes  = in_spikes_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb/tb_spike_rate_encoder.sv - self-checking bench for spike_rate_encoder
module tb_spike_rate_encoder;

  localparam int NI = 4;
  localparam int PW = 8;
  localparam int NS = 10;
  localparam int DW = NI * PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [DW-1:0] pix_data = '0;
  logic          sample = 1'b0;
  logic          sample_ready;
  logic [NI-1:0] in_spikes;
  logic          frame_done;

  int checks = 0;
  int failures = 0;

  // Reference model state: pending frames (front is active), steps done, LFSR
  logic [DW-1:0] mq[$];
  int            m_step;
  logic [15:0]   m_lfsr;
  logic [NI-1:0] m_spikes;

  spike_rate_encoder #(
    .N_INPUTS   (NI),
    .PIX_W      (PW),
    .N_STEPS    (NS),
    .STEP_CNT_W (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .sample       (sample),
    .sample_ready (sample_ready),
    .in_spikes    (in_spikes),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // Feedback mask derived from the polynomial exponents 16,14,13,11
  function automatic logic [15:0] ref_lfsr_step(input logic [15:0] x);
    int exps[4] = '{16, 14, 13, 11};
    logic [15:0] mask = '0;
    foreach (exps[k]) mask[exps[k]-1] = 1'b1;
    return x[0] ? ((x >> 1) ^ mask) : (x >> 1);
  endfunction

  function automatic logic [NI-1:0] ref_spikes(input logic [DW-1:0] frame, input logic [15:0] r);
    logic [NI-1:0] s;
    for (int i = 0; i < NI; i++) begin
      int px, rnd;
      px  = int'(frame[i*PW +: PW]);
      rnd = int'((r >> (2 * i)) & 16'h00FF);
      s[i] = (px > rnd);
    end
    return s;
  endfunction

  function automatic int popcount(input logic [NI-1:0] v);
    int c = 0;
    for (int i = 0; i < NI; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_step   = 0;
    m_lfsr   = 16'hACE1;
    m_spikes = '0;
  endtask

  // Drive one clock with the given inputs, advance the model, and return
  // the expected registered outputs visible after the edge.
  task automatic tick(input bit s, input bit p, input logic [DW-1:0] d,
                      output logic [NI-1:0] exp_sp, output bit exp_done);
    int pre_size;
    sample = s; pix_valid = p; pix_data = d;
    pre_size = mq.size();
    exp_done = 1'b0;
    if (s && pre_size > 0) begin
      m_spikes = ref_spikes(mq[0], m_lfsr);
      m_lfsr   = ref_lfsr_step(m_lfsr);
      m_step++;
      if (m_step == NS) begin
        void'(mq.pop_front());
        m_step   = 0;
        exp_done = 1'b1;
      end
    end else if (pre_size == 0) begin
      m_spikes = '0;
    end
    if (p && pre_size < 2) mq.push_back(d);
    @(posedge clk);
    #1;
    sample = 1'b0; pix_valid = 1'b0;
    exp_sp = m_spikes;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL reset_pix_ready got=%b exp=1", pix_ready); end
    checks++; if (sample_ready !== 1'b0) begin failures++; $display("FAIL reset_sample_ready got=%b exp=0", sample_ready); end
    checks++; if (in_spikes !== '0) begin failures++; $display("FAIL reset_in_spikes got=%b exp=0", in_spikes); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_zero_frame();
    logic [NI-1:0] es; bit ed; int dones = 0;
    tick(0, 1, '0, es, ed);
    for (int k = 0; k < NS; k++) begin
      tick(1, 0, '0, es, ed);
      if (frame_done) dones++;
      checks++; if (in_spikes !== '0) begin failures++; $display("FAIL zero_spikes step=%0d got=%b exp=0", k, in_spikes); end
    end
    tick(0, 0, '0, es, ed);
    if (frame_done) dones++;
    checks++; if (dones != 1) begin failures++; $display("FAIL zero_frame_done_count got=%0d exp=1", dones); end
    checks++; if (sample_ready !== 1'b0) begin failures++; $display("FAIL zero_sample_ready_after got=%b exp=0", sample_ready); end
  endtask

  task automatic test_full_frame();
    logic [NI-1:0] es; bit ed; int got_cnt = 0; int exp_cnt = 0;
    tick(0, 1, {DW{1'b1}}, es, ed);
    for (int k = 0; k < NS; k++) begin
      tick(1, 0, '0, es, ed);
      got_cnt += popcount(in_spikes);
      exp_cnt += popcount(es);
      checks++; if (in_spikes !== es) begin failures++; $display("FAIL full_spikes step=%0d got=%b exp=%b", k, in_spikes, es); end
      checks++; if (frame_done !== ed) begin failures++; $display("FAIL full_frame_done step=%0d got=%b exp=%b", k, frame_done, ed); end
    end
    checks++; if (got_cnt != exp_cnt) begin failures++; $display("FAIL full_spike_count got=%0d exp=%0d", got_cnt, exp_cnt); end
    tick(0, 0, '0, es, ed);
  endtask

  task automatic test_idle_sample();
    logic [NI-1:0] es; bit ed; logic [DW-1:0] f;
    tick(0, 0, '0, es, ed);
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, '0, es, ed);
      checks++; if (in_spikes !== '0) begin failures++; $display("FAIL idle_spikes got=%b exp=0", in_spikes); end
      checks++; if (sample_ready !== 1'b0) begin failures++; $display("FAIL idle_sample_ready got=%b exp=0", sample_ready); end
    end
    // First steps of a new frame expose whether the idle samples moved the LFSR or counter
    f = $urandom();
    tick(0, 1, f, es, ed);
    for (int k = 0; k < NS; k++) begin
      tick(1, 0, '0, es, ed);
      checks++; if (in_spikes !== es) begin failures++; $display("FAIL idle_then_spikes step=%0d got=%b exp=%b", k, in_spikes, es); end
      checks++; if (frame_done !== ed) begin failures++; $display("FAIL idle_then_done step=%0d got=%b exp=%b", k, frame_done, ed); end
    end
  endtask

  task automatic test_back_to_back();
    logic [NI-1:0] es; bit ed; logic [DW-1:0] fa, fb;
    fa = $urandom(); fb = ~fa;
    tick(0, 1, fa, es, ed);
    tick(0, 1, fb, es, ed);
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL b2b_pix_ready_full got=%b exp=0", pix_ready); end
    for (int k = 0; k < 2 * NS; k++) begin
      tick(1, 0, '0, es, ed);
      checks++; if (in_spikes !== es) begin failures++; $display("FAIL b2b_spikes step=%0d got=%b exp=%b", k, in_spikes, es); end
      checks++; if (frame_done !== ed) begin failures++; $display("FAIL b2b_done step=%0d got=%b exp=%b", k, frame_done, ed); end
      checks++; if (sample_ready !== (mq.size() > 0)) begin failures++; $display("FAIL b2b_sample_ready step=%0d got=%b exp=%b", k, sample_ready, mq.size() > 0); end
      checks++; if (pix_ready !== (mq.size() < 2)) begin failures++; $display("FAIL b2b_pix_ready step=%0d got=%b exp=%b", k, pix_ready, mq.size() < 2); end
    end
  endtask

  task automatic test_reset_mid();
    logic [NI-1:0] es; bit ed; logic [DW-1:0] f;
    f = $urandom();
    tick(0, 1, f, es, ed);
    for (int k = 0; k < 5; k++) tick(1, 0, '0, es, ed);
    rst_n = 1'b0;
    #1;
    checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL midrst_pix_ready got=%b exp=1", pix_ready); end
    checks++; if (sample_ready !== 1'b0) begin failures++; $display("FAIL midrst_sample_ready got=%b exp=0", sample_ready); end
    checks++; if (in_spikes !== '0) begin failures++; $display("FAIL midrst_in_spikes got=%b exp=0", in_spikes); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL midrst_frame_done got=%b exp=0", frame_done); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    tick(0, 1, f, es, ed);
    for (int k = 0; k < NS; k++) begin
      tick(1, 0, '0, es, ed);
      checks++; if (in_spikes !== es) begin failures++; $display("FAIL midrst_replay step=%0d got=%b exp=%b", k, in_spikes, es); end
      checks++; if (frame_done !== ed) begin failures++; $display("FAIL midrst_done step=%0d got=%b exp=%b", k, frame_done, ed); end
    end
  endtask

  task automatic test_coincide();
    logic [NI-1:0] es; bit ed; logic [DW-1:0] fa, fc;
    fa = $urandom(); fc = $urandom();
    tick(0, 0, '0, es, ed);
    tick(0, 1, fa, es, ed);
    for (int k = 0; k < NS - 1; k++) tick(1, 0, '0, es, ed);
    tick(1, 1, fc, es, ed);
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL coin_frame_done got=%b exp=1", frame_done); end
    checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL coin_sample_ready got=%b exp=1", sample_ready); end
    checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL coin_pix_ready got=%b exp=1", pix_ready); end
    for (int k = 0; k < NS; k++) begin
      tick(1, 0, '0, es, ed);
      checks++; if (in_spikes !== es) begin failures++; $display("FAIL coin_spikes step=%0d got=%b exp=%b", k, in_spikes, es); end
      checks++; if (frame_done !== ed) begin failures++; $display("FAIL coin_done step=%0d got=%b exp=%b", k, frame_done, ed); end
    end
  endtask

  task automatic test_random();
    logic [NI-1:0] es; bit ed; bit s, p; logic [DW-1:0] d;
    for (int k = 0; k < 200; k++) begin
      s = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 4) == 0);
      d = $urandom();
      tick(s, p, d, es, ed);
      checks++; if (in_spikes !== es) begin failures++; $display("FAIL rand_spikes cyc=%0d got=%b exp=%b", k, in_spikes, es); end
      checks++; if (frame_done !== ed) begin failures++; $display("FAIL rand_done cyc=%0d got=%b exp=%b", k, frame_done, ed); end
      checks++; if (sample_ready !== (mq.size() > 0)) begin failures++; $display("FAIL rand_sample_ready cyc=%0d got=%b exp=%b", k, sample_ready, mq.size() > 0); end
      checks++; if (pix_ready !== (mq.size() < 2)) begin failures++; $display("FAIL rand_pix_ready cyc=%0d got=%b exp=%b", k, pix_ready, mq.size() < 2); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_zero_frame();
    test_full_frame();
    test_idle_sample();
    test_back_to_back();
    test_reset_mid();
    test_coincide();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
